// File: rtl/traffic_pkg.sv
// Shared lane-FSM state codes, phase classes and state decoder
// for the traffic light scheduler and lane FSM.
package traffic_pkg;

  localparam logic [1:0] LANE_NS = 2'd0;
  localparam logic [1:0] LANE_SN = 2'd1;
  localparam logic [1:0] LANE_EW = 2'd2;
  localparam logic [1:0] LANE_WE = 2'd3;

  // Gray sequence along the nominal phase order
  localparam logic [3:0] NS_RED      = 4'h0;
  localparam logic [3:0] NS_PRIMARY  = 4'h1;
  localparam logic [3:0] NS_EXTENDED = 4'h3;
  localparam logic [3:0] NS_YELLOW   = 4'h2;
  localparam logic [3:0] SN_RED      = 4'h6;
  localparam logic [3:0] SN_PRIMARY  = 4'h7;
  localparam logic [3:0] SN_EXTENDED = 4'h5;
  localparam logic [3:0] SN_YELLOW   = 4'h4;
  localparam logic [3:0] EW_RED      = 4'hC;
  localparam logic [3:0] EW_PRIMARY  = 4'hD;
  localparam logic [3:0] EW_EXTENDED = 4'hF;
  localparam logic [3:0] EW_YELLOW   = 4'hE;
  localparam logic [3:0] WE_RED      = 4'hA;
  localparam logic [3:0] WE_PRIMARY  = 4'hB;
  localparam logic [3:0] WE_EXTENDED = 4'h9;
  localparam logic [3:0] WE_YELLOW   = 4'h8;

  typedef enum logic [2:0] {
    CLS_RED,
    CLS_PRIMARY,
    CLS_EXTENDED,
    CLS_YELLOW,
    CLS_INVALID
  } phase_class_e;

  typedef struct packed {
    logic [1:0]   lane;
    phase_class_e cls;
  } phase_t;

  function automatic phase_t decode_state(input logic [3:0] s);
    phase_t p;
    case (s)
      NS_RED:      p = '{LANE_NS, CLS_RED};
      NS_PRIMARY:  p = '{LANE_NS, CLS_PRIMARY};
      NS_EXTENDED: p = '{LANE_NS, CLS_EXTENDED};
      NS_YELLOW:   p = '{LANE_NS, CLS_YELLOW};
      SN_RED:      p = '{LANE_SN, CLS_RED};
      SN_PRIMARY:  p = '{LANE_SN, CLS_PRIMARY};
      SN_EXTENDED: p = '{LANE_SN, CLS_EXTENDED};
      SN_YELLOW:   p = '{LANE_SN, CLS_YELLOW};
      EW_RED:      p = '{LANE_EW, CLS_RED};
      EW_PRIMARY:  p = '{LANE_EW, CLS_PRIMARY};
      EW_EXTENDED: p = '{LANE_EW, CLS_EXTENDED};
      EW_YELLOW:   p = '{LANE_EW, CLS_YELLOW};
      WE_RED:      p = '{LANE_WE, CLS_RED};
      WE_PRIMARY:  p = '{LANE_WE, CLS_PRIMARY};
      WE_EXTENDED: p = '{LANE_WE, CLS_EXTENDED};
      WE_YELLOW:   p = '{LANE_WE, CLS_YELLOW};
      default:     p = '{LANE_NS, CLS_INVALID};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/FSM-facing bundle of the phase scheduler.
// TRAFFIC_HOLD_EN adds the hold input.
interface traffic_phase_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic [3:0]       state;
  logic [3:0]       s1_raw;
  logic [3:0]       s5_raw;
  logic             fsm_step;
  logic [3:0]       s1_req;
  logic [3:0]       s5_cong;
  logic [CNT_W-1:0] remaining;
`ifdef TRAFFIC_HOLD_EN
  logic             hold;

  modport master (
    output tick, state, s1_raw, s5_raw, hold,
    input  fsm_step, s1_req, s5_cong, remaining
  );
  modport slave (
    input  tick, state, s1_raw, s5_raw, hold,
    output fsm_step, s1_req, s5_cong, remaining
  );
`else
  modport master (
    output tick, state, s1_raw, s5_raw,
    input  fsm_step, s1_req, s5_cong, remaining
  );
  modport slave (
    input  tick, state, s1_raw, s5_raw,
    output fsm_step, s1_req, s5_cong, remaining
  );
`endif
endinterface

// File: rtl/traffic_dwell_counter.sv
// Dwell countdown: loads on phase entry, counts timebase ticks
// and emits a one-cycle step when the dwell expires.
module traffic_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             hold,
  output logic [CNT_W-1:0] remaining,
  output logic             step
);

  logic adv;

  assign adv = tick & ~hold & (remaining != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      step      <= 1'b0;
    end else if (load) begin
      remaining <= load_val;
      step      <= 1'b0;
    end else if (adv) begin
      remaining <= remaining - CNT_W'(1);
      step      <= (remaining == CNT_W'(1));
    end else begin
      step      <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Phase dwell timing and sticky request conditioning for the lane FSM.
// TRAFFIC_HOLD_EN enables the hold input (freezes non-yellow dwells).
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 20,
  parameter int GREEN_EXT = 15,
  parameter int YELLOW_T  = 4,
  parameter int RED_T     = 2
) (
  input  logic                clk,
  input  logic                rst,
  traffic_phase_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] DW_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DW_PRI =
    CNT_W'((GREEN_MIN < 1) ? 1 : GREEN_MIN);
  localparam logic [CNT_W-1:0] DW_EXT =
    CNT_W'((GREEN_EXT < 1) ? 1 : GREEN_EXT);
  localparam logic [CNT_W-1:0] DW_YEL =
    CNT_W'((YELLOW_T < 1) ? 1 : YELLOW_T);
  localparam logic [CNT_W-1:0] DW_RED =
    CNT_W'((RED_T < 1) ? 1 : RED_T);

  phase_t           ph;
  logic [3:0]       state_q;
  logic             first_q;
  logic             entry;
  logic [3:0]       served;
  logic [3:0]       s1_q;
  logic [3:0]       s5_q;
  logic [CNT_W-1:0] load_val;
  logic             hold_eff;
  logic [CNT_W-1:0] rem;
  logic             step;

  assign ph    = decode_state(bus.state);
  assign entry = first_q | (bus.state != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= bus.state;
      first_q <= 1'b0;
    end
  end

  always_comb begin
    served = '0;
    if (entry && ph.cls == CLS_PRIMARY)
      served[ph.lane] = 1'b1;
  end

  // A raw sensor still high on the serving cycle re-arms the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s5_q <= '0;
    end else begin
      s1_q <= bus.s1_raw | (s1_q & ~served);
      s5_q <= (s5_q | bus.s5_raw) & ~served;
    end
  end

  always_comb begin
    load_val = DW_ONE;
    case (ph.cls)
      CLS_PRIMARY:  load_val = DW_PRI;
      CLS_EXTENDED: load_val = DW_EXT;
      CLS_YELLOW:   load_val = DW_YEL;
      CLS_RED:      load_val = s1_q[ph.lane] ? DW_RED : DW_ONE;
      default:      load_val = DW_ONE;
    endcase
  end

`ifdef TRAFFIC_HOLD_EN
  // Yellow always runs out so a held lane never strands a yellow
  assign hold_eff = bus.hold &
    ((ph.cls == CLS_RED) |
     (ph.cls == CLS_PRIMARY) |
     (ph.cls == CLS_EXTENDED));
`else
  assign hold_eff = 1'b0;
`endif

  traffic_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .load      (entry),
    .load_val  (load_val),
    .tick      (bus.tick),
    .hold      (hold_eff),
    .remaining (rem),
    .step      (step)
  );

  assign bus.fsm_step  = step;
  assign bus.remaining = rem;
  assign bus.s1_req    = s1_q;
  assign bus.s5_cong   = s5_q;

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Timing and request-conditioning front end for `traffic_light_fsm`. It holds each FSM state for a programmable number of timebase ticks and issues a single-cycle `fsm_step` used as the lane FSM's clock enable. It also latches raw lane sensors into sticky request and congestion bits, which feed the FSM's S1/S5 inputs. It sits between the sensor inputs and the lane FSM, and observes the FSM's current state.

## Interface
- `CNT_W`, 8: dwell counter width.
- `GREEN_MIN`, 20: PRIMARY_GREEN dwell, in ticks.
- `GREEN_EXT`, 15: EXTENDED_GREEN dwell, in ticks.
- `YELLOW_T`, 4: YELLOW dwell, in ticks.
- `RED_T`, 2: RED clearance dwell when the lane has a pending request, in ticks.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-cycle timebase pulse.
- `state`  in  4  current lane FSM state (Gray-coded encoding).
- `s1_raw`  in  4  raw start sensors, bit order [0]=NS, [1]=SN, [2]=EW, [3]=WE.
- `s5_raw`  in  4  raw congestion sensors, same bit order.
- `fsm_step`  out  1  one-cycle advance enable to the lane FSM.
- `s1_req`  out  4  sticky start requests, driving the FSM S1 inputs.
- `s5_cong`  out  4  sticky congestion flags, driving the FSM S5 inputs.
- `remaining`  out  CNT_W  ticks left in the current dwell.
- `hold`  in  1  present only with `TRAFFIC_HOLD_EN`.

## Operation
- **State decode.** `state` decodes to {lane, class}, where class is RED, PRIMARY, EXTENDED or YELLOW. An unrecognised code decodes to class INVALID.
- **Entry detection.** `state` differing from the registered `state_q` marks an entry cycle. Reset also forces the first cycle after reset to be treated as an entry.
- **Dwell selection on entry:**
  - PRIMARY loads GREEN_MIN.
  - EXTENDED loads GREEN_EXT.
  - YELLOW loads YELLOW_T.
  - RED loads RED_T if `s1_req[lane]` is 1, otherwise 1 (fast skip).
  - INVALID loads 1.
  - A parameter value of 0 is clamped to 1.
- **Countdown:**
  - Ticks arriving in the entry cycle are ignored.
  - Afterwards, a tick with `remaining`>1 decrements it.
  - A tick with `remaining`==1 sets it to 0 and registers `fsm_step`=1 for exactly one cycle.
  - While `remaining`==0, no further steps are issued until the next entry.
- **Start requests.** `s1_req[i]` next value = `s1_raw[i]` OR (`s1_req[i]` AND NOT served_i). served_i is true on the entry cycle into lane i's PRIMARY. If the raw sensor is still high on that cycle, the set wins.
- **Congestion flags.** `s5_cong[i]` clears on entry to lane i's PRIMARY. From the following cycle it OR-accumulates `s5_raw[i]` until the next entry of lane i. The FSM therefore sees congestion that occurred at any time during the primary green.
- **Reset values.** All outputs are 0, `state_q`=0 and the entry flag is set.
- **Reset mid-dwell.** The countdown aborts immediately and all requests are lost.

## Timing
- With entry at cycle E and `tick` high every cycle:
  - `remaining`=D is visible at E+1.
  - `fsm_step`=1 is asserted at cycle E+D+1.
  - The FSM state changes at E+D+2, which is the next entry cycle.
- Minimum phase length is 2 clk cycles plus D ticks.
- `fsm_step` is never high on two consecutive cycles.
- A `state` change without a preceding step is still treated as an entry and reloads the counter.

## Configuration
- **`TRAFFIC_HOLD_EN` defined:**
  - Adds the `hold` input.
  - While `hold`=1 in class RED, PRIMARY or EXTENDED, ticks are ignored and `fsm_step` is suppressed; `remaining` is frozen.
  - During YELLOW, `hold` has no effect, so yellow always completes.
  - Request and congestion latching continue during hold.
- **Undefined:** no `hold` port; behaviour is identical to `hold`=0.

## Structure
- **Shared package `traffic_pkg`:**
  - the 16 state localparams;
  - the class typedef (RED/PRIMARY/EXTENDED/YELLOW/INVALID);
  - lane index constants;
  - the `decode_state` function returning {lane, class}.

  The lane FSM is moved onto the same package constants.
- **Sub-module `traffic_dwell_counter`:** load, tick, hold and step logic, parameterised by `CNT_W`.

## Test plan
Common setup for all scenarios: GREEN_MIN=3, GREEN_EXT=2, YELLOW_T=2, RED_T=1, `tick` held high, FSM model gated by `fsm_step`.

- **Empty-lane skip.** Reset, all sensors 0 → each RED state dwells 1 tick, `fsm_step` every 3 cycles, FSM cycles NS_RED→SN_RED→EW_RED→WE_RED→NS_RED.
- **Single request.** `s1_raw[0]` pulsed for 1 cycle during WE_RED → `s1_req[0]` stays 1. NS_PRIMARY is entered, then `s1_req[0]` clears on the entry cycle, and `remaining` reads 3 one cycle later.
- **Congestion.** `s5_raw[1]` pulses once mid SN_PRIMARY → SN_EXTENDED is entered, giving a 2-tick dwell, then SN_YELLOW with a 2-tick dwell.
- **Sparse ticks.** `tick` every 4th cycle in YELLOW with D=2 → `fsm_step` occurs one cycle after the 2nd post-entry tick; no step occurs while `remaining`=0.
- **Reset mid-dwell.** Assert `rst` with `remaining`=2 in EW_PRIMARY → all outputs 0 immediately. After release, NS_RED is treated as an entry.
- **Hold (`TRAFFIC_HOLD_EN`).** `hold`=1 for 10 cycles in NS_PRIMARY → `remaining` is frozen and there is no step. The same hold applied in NS_YELLOW → the step still occurs on schedule.
